extsi_ui_elastic: RTL
=====================

Name: extsi_ui_elastic

Overview:
- Parametrised successor to the combinational unsigned-extension arith unit.
- Performs zero-extension, sign-extension or truncation, chosen per token, with a built-in 2-slot elastic buffer.
- Registered valid and ready on both sides break combinational handshake paths. Full throughput is kept: one token per cycle.
- Sits in arith datapaths between dataflow units wherever width changes coincide with timing-critical handshake chains.

Parameters:
- INPUT_WIDTH, 32, width of the ins data.
- OUTPUT_WIDTH, 64, width of the outs data. Any value >= 1, including values smaller than INPUT_WIDTH.
- SIGN_DEFAULT, 0, value used in place of ins_sign when USE_SIGN_PORT=0 (0 = zero-extend, 1 = sign-extend).
- USE_SIGN_PORT, 1, when 1 the ins_sign port selects the mode per token; when 0 the ins_sign port is ignored.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- ins  input  INPUT_WIDTH  operand.
- ins_sign  input  1  per-token mode; 1 = sign-extend, 0 = zero-extend. Sampled with ins.
- ins_valid  input  1  producer valid.
- ins_ready  output  1  consumer ready (registered).
- outs  output  OUTPUT_WIDTH  extended result (registered).
- outs_valid  output  1  result valid (registered).
- outs_ready  input  1  downstream ready.
- occupancy  output  2  tokens held, 0..2; debug and verification aid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values while rst=0, and on the first edge after release:
  - state EMPTY, occupancy 0.
  - outs_valid 0, outs all-zero, ins_ready 1, skid register all-zero.
- Width rule, applied at acceptance time, so stored values are already OUTPUT_WIDTH wide:
  - OUTPUT_WIDTH > INPUT_WIDTH: upper OUTPUT_WIDTH-INPUT_WIDTH bits are ins[INPUT_WIDTH-1] if the effective sign is 1, else 0.
  - OUTPUT_WIDTH = INPUT_WIDTH: pass-through.
  - OUTPUT_WIDTH < INPUT_WIDTH: outs = ins[OUTPUT_WIDTH-1:0]; the mode has no effect.
- Effective sign = ins_sign if USE_SIGN_PORT=1, else SIGN_DEFAULT.
- Transfer definitions:
  - Input transfer: ins_valid & ins_ready at the edge.
  - Output transfer: outs_valid & outs_ready at the edge.
- Latency: an input transfer at edge N makes the token visible on outs/outs_valid after edge N, i.e. 1 cycle.
- States (the output register is the main slot; the skid register is the second slot):
  - EMPTY: outs_valid=0, ins_ready=1.
    - Input transfer -> ONE; token loads the output register.
  - ONE: outs_valid=1, ins_ready=1.
    - Input and output transfer together -> stay ONE; new token replaces outs.
    - Input transfer only -> TWO; token loads the skid register.
    - Output transfer only -> EMPTY.
    - Neither -> hold.
  - TWO: outs_valid=1, ins_ready=0.
    - Output transfer -> ONE; skid moves into the output register.
    - No input can be accepted in TWO.
- Hold rules:
  - outs and outs_valid are stable while outs_valid=1 and outs_ready=0.
  - Data is never dropped or duplicated; token order is preserved.
- ins_ready is a register output. It must not depend combinationally on outs_ready. Same for outs_valid on ins_valid.
- Reset mid-operation: all held tokens are discarded; outputs take reset values immediately (asynchronous).
- Boundary conditions:
  - outs_ready held low with ins_valid high: exactly 2 tokens are accepted, then ins_ready=0.
  - Continuous valid/ready: sustained 1 token/cycle with zero bubbles.
- occupancy = 0/1/2 for EMPTY/ONE/TWO.

Decomposition:
- Shared package arith_pkg:
  - State encoding constants EXT_EMPTY=2'd0, EXT_ONE=2'd1, EXT_TWO=2'd2.
  - A width-extension function ext_value(data, sign, in_w, out_w), reusable by future extsi/trunc units.
- One sub-module is natural: elastic_skid_2slot.
  - Generic DATA_WIDTH 2-slot registered-handshake buffer.
  - Contains the state machine and occupancy output.
- The top level instantiates elastic_skid_2slot with DATA_WIDTH=OUTPUT_WIDTH, feeding it the combinational extension of ins/ins_sign.

Test Plan:
- Extension modes (INPUT_WIDTH=8, OUTPUT_WIDTH=16), outs_ready=1:
  - ins=8'h85, ins_sign=1 -> outs=16'hFF85 one cycle later.
  - ins=8'h85, ins_sign=0 -> outs=16'h0085.
  - ins=8'h7F, ins_sign=1 -> outs=16'h007F.
- Truncation (INPUT_WIDTH=16, OUTPUT_WIDTH=8): ins=16'hABCD with either sign -> outs=8'hCD.
- Backpressure: outs_ready=0, ins_valid=1 with tokens 1, 2, 3 ->
  - tokens 1 and 2 accepted, ins_ready=0 from the cycle after the second acceptance, occupancy=2.
  - outs holds 1 stable.
  - Raise outs_ready -> outputs 1, 2, 3 in order, no loss.
- Throughput: 100 back-to-back tokens with both valid and ready held high -> 100 outputs in 100 consecutive cycles after the 1-cycle latency, occupancy stays 1.
- Reset mid-stream: rst=0 asserted while in state TWO ->
  - outs_valid=0, ins_ready=1, occupancy=0 asynchronously, before the next clock edge.
  - First post-reset token appears alone.
- Random valid/ready stalls, 10k tokens, scoreboard against the extension reference -> exact match. Assertion: ins_ready has no combinational path from outs_ready.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arith definitions: elastic-buffer state encoding and a generic
// width-extension helper used by the extsi/trunc family of units.
package arith_pkg;

  // Widest operand the extension helper supports.
  localparam int EXT_MAX_W = 256;

  typedef enum logic [1:0] {
    EXT_EMPTY = 2'd0,
    EXT_ONE   = 2'd1,
    EXT_TWO   = 2'd2
  } ext_state_e;

  // Zero/sign-extend or truncate the low in_w bits of data to out_w bits.
  // Bits at and above out_w in the result are always zero.
  function automatic logic [EXT_MAX_W-1:0] ext_value(
    input logic [EXT_MAX_W-1:0] data,
    input logic                 sign,
    input int                   in_w,
    input int                   out_w
  );
    logic [EXT_MAX_W-1:0] ones, one_bit, in_mask, out_mask, res;
    logic                 msb;
    ones     = '1;
    one_bit  = {{(EXT_MAX_W-1){1'b0}}, 1'b1};
    in_mask  = ~(ones << in_w);
    out_mask = ~(ones << out_w);
    msb      = |(data & (one_bit << (in_w - 1)));
    res      = data & in_mask;
    if (sign && msb) res = res | ~in_mask;
    return res & out_mask;
  endfunction

endpackage

// File: rtl/elastic_skid_2slot.sv
// Two-slot elastic buffer with fully registered valid/ready on both sides.
// The output register is the main slot; the skid register absorbs one token of backpressure.
module elastic_skid_2slot
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  ext_state_e            state;
  logic [DATA_WIDTH-1:0] skid;
  logic                  in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EXT_EMPTY;
      occupancy <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      skid      <= '0;
    end else begin
      case (state)
        EXT_EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            occupancy <= 2'd1;
            state     <= EXT_ONE;
          end
        end
        EXT_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            skid      <= in_data;
            in_ready  <= 1'b0;
            occupancy <= 2'd2;
            state     <= EXT_TWO;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            state     <= EXT_EMPTY;
          end
        end
        EXT_TWO: begin
          if (out_xfer) begin
            out_data  <= skid;
            in_ready  <= 1'b1;
            occupancy <= 2'd1;
            state     <= EXT_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          occupancy <= 2'd0;
          state     <= EXT_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/extsi_ui_elastic.sv
// Per-token zero/sign extension or truncation ahead of a 2-slot elastic buffer,
// so the stored tokens are already OUTPUT_WIDTH wide.
module extsi_ui_elastic
  import arith_pkg::*;
#(
  parameter int INPUT_WIDTH   = 32,
  parameter int OUTPUT_WIDTH  = 64,
  parameter int SIGN_DEFAULT  = 0,
  parameter int USE_SIGN_PORT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  ins,
  input  logic                    ins_sign,
  input  logic                    ins_valid,
  output logic                    ins_ready,
  output logic [OUTPUT_WIDTH-1:0] outs,
  output logic                    outs_valid,
  input  logic                    outs_ready,
  output logic [1:0]              occupancy
);

  logic                    eff_sign;
  logic [OUTPUT_WIDTH-1:0] ext;

  assign eff_sign = (USE_SIGN_PORT != 0) ? ins_sign : (SIGN_DEFAULT != 0);
  assign ext      = OUTPUT_WIDTH'(ext_value(EXT_MAX_W'(ins), eff_sign, INPUT_WIDTH, OUTPUT_WIDTH));

  elastic_skid_2slot #(
    .DATA_WIDTH(OUTPUT_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_data  (ext),
    .in_valid (ins_valid),
    .in_ready (ins_ready),
    .out_data (outs),
    .out_valid(outs_valid),
    .out_ready(outs_ready),
    .occupancy(occupancy)
  );

endmodule
